// File: rtl/obstacle_spawner_pkg.sv
// Shared game package: lane/id types, spawn entry layout, FSM states, defaults
// and the lane-selection helper used by the obstacle spawner.
package obstacle_spawner_pkg;

    typedef logic [1:0] lane_t;
    typedef logic [7:0] spawn_id_t;

    // Queue entry layout: {lane, id}, 10 bits
    typedef struct packed {
        lane_t     lane;
        spawn_id_t id;
    } spawn_entry_t;

    localparam int unsigned NUM_LANES_DEFAULT    = 3;
    localparam int unsigned SPAWN_PERIOD_DEFAULT = 50;

    typedef enum logic {StIdle, StRun} spawn_state_t;

    // Fold the raw 2-bit sample into the legal lane range, then step past the
    // previously accepted lane so two consecutive obstacles never share a lane.
    function automatic lane_t pick_lane(input logic [1:0]  raw,
                                        input lane_t       last_lane,
                                        input logic        have_last,
                                        input int unsigned num_lanes);
        lane_t lane;
        if (32'(raw) < num_lanes) begin
            lane = raw;
        end else begin
            lane = lane_t'(32'(raw) - num_lanes);
        end
        if (have_last && lane == last_lane) begin
            lane = (32'(lane) == num_lanes - 1) ? 2'd0 : lane + 2'd1;
        end
        return lane;
    endfunction

endpackage

// File: rtl/obstacle_spawner_fifo.sv
// spawn_fifo: synchronous FIFO for pending spawn entries.
// Ports:
//   clock, reset     - rising-edge clock, synchronous active-high reset
//   push, push_data  - write request and data (ignored when full unless popping)
//   pop, pop_data    - read request and head data (pop ignored when empty)
//   full, empty      - occupancy flags
//   count            - entries currently held (0..DEPTH)
// DEPTH must be a power of two and at least 2.
module spawn_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] hold_q;
    logic             do_pop, do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // When empty, keep presenting the entry that was last popped.
    assign pop_data = empty ? hold_q : mem[rd_ptr_q];
    assign count    = count_q;

    always_ff @(posedge clock) begin
        if (do_push && !reset) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                hold_q   <= mem[rd_ptr_q];
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/obstacle_spawner.sv
// obstacle_spawner: periodically samples an upstream random value, maps it to a
// non-repeating lane and queues {lane, id} spawn requests for a consumer.
// Ports:
//   clock, reset             - rising-edge clock, synchronous active-high reset
//   enable                   - runs the spawn timer; low pauses it (queue still drains)
//   randnum[2:0]             - random sample, only bits [1:0] used
//   spawn_ready              - consumer accepts the head entry
//   spawn_valid              - queue non-empty, head presented on spawn_lane/spawn_id
//   spawn_lane, spawn_id     - head entry (last value held while empty)
//   fifo_count               - entries queued
//   dropped                  - one-cycle pulse after a sample was lost to a full queue
module obstacle_spawner
    import obstacle_spawner_pkg::*;
#(
    parameter int unsigned SPAWN_PERIOD = SPAWN_PERIOD_DEFAULT,
    parameter int unsigned NUM_LANES    = NUM_LANES_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] randnum,
    input  logic       spawn_ready,
    output logic       spawn_valid,
    output lane_t      spawn_lane,
    output spawn_id_t  spawn_id,
    output logic [2:0] fifo_count,
    output logic       dropped
);

    localparam int unsigned CTR_W = $clog2(SPAWN_PERIOD);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    spawn_state_t     state_q, state_d;
    logic [CTR_W-1:0] counter_q, counter_d;
    spawn_id_t        next_id_q;
    lane_t            last_lane_q;
    logic             have_last_q;
    logic             dropped_q;

    logic             running, tick, push, pop;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_cnt;
    lane_t            lane;
    spawn_entry_t     push_entry, head;
    logic             unused_rand;

    assign unused_rand = randnum[2];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable)  state_d = StRun;
            StRun:   if (!enable) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The timer follows the state being entered, so the first enabled cycle
    // already counts and a pause holds the counter exactly where it stopped.
    assign running = (state_d == StRun);
    assign tick    = running && (counter_q == CTR_W'(SPAWN_PERIOD - 1));

    always_comb begin
        counter_d = counter_q;
        if (running) begin
            counter_d = tick ? '0 : counter_q + CTR_W'(1);
        end
    end

    assign lane       = pick_lane(randnum[1:0], last_lane_q, have_last_q, NUM_LANES);
    assign push_entry = '{lane: lane, id: next_id_q};

    assign spawn_valid = !fifo_empty;
    assign pop         = spawn_valid && spawn_ready;
    assign push        = tick && (!fifo_full || pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            counter_q   <= '0;
            next_id_q   <= '0;
            last_lane_q <= '0;
            have_last_q <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            dropped_q <= tick && !push;
            if (push) begin
                next_id_q   <= next_id_q + 8'd1;
                last_lane_q <= lane;
                have_last_q <= 1'b1;
            end
        end
    end

    spawn_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(spawn_entry_t))
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign spawn_lane = head.lane;
    assign spawn_id   = head.id;
    assign fifo_count = 3'(fifo_cnt);
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
module tb_obstacle_spawner;

    localparam int P = 4;
    localparam int N = 3;
    localparam int D = 4;

    logic       clock = 1'b0;
    logic       reset, enable, spawn_ready;
    logic [2:0] randnum;
    logic       spawn_valid, dropped;
    logic [1:0] spawn_lane;
    logic [7:0] spawn_id;
    logic [2:0] fifo_count;

    always #5 clock = ~clock;

    obstacle_spawner #(
        .SPAWN_PERIOD (P),
        .NUM_LANES    (N),
        .FIFO_DEPTH   (D)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .randnum     (randnum),
        .spawn_ready (spawn_ready),
        .spawn_valid (spawn_valid),
        .spawn_lane  (spawn_lane),
        .spawn_id    (spawn_id),
        .fifo_count  (fifo_count),
        .dropped     (dropped)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: a queue of pending spawns and an enabled-cycle count.
    typedef struct {
        int lane;
        int id;
    } ent_t;

    ent_t q[$];
    int   m_cnt, m_next_id, m_last, m_has_last, m_shown_lane, m_shown_id, m_dropped;

    task automatic model_step(input bit en, input int rn, input bit rdy, input bit rst);
        bit pop, tick, accept;
        int raw, lane;
        if (rst) begin
            q.delete();
            m_cnt = 0; m_next_id = 0; m_last = 0; m_has_last = 0;
            m_shown_lane = 0; m_shown_id = 0; m_dropped = 0;
            return;
        end
        pop    = (q.size() > 0) && rdy;
        tick   = en && (m_cnt == P - 1);
        accept = 0;
        lane   = 0;
        if (en) m_cnt = (m_cnt + 1) % P;
        if (tick) begin
            raw  = rn % 4;
            lane = (raw < N) ? raw : raw - N;
            if (m_has_last && lane == m_last) lane = (lane + 1) % N;
            accept = (q.size() < D) || pop;
        end
        if (pop) begin
            m_shown_lane = q[0].lane;
            m_shown_id   = q[0].id;
            void'(q.pop_front());
        end
        if (accept) begin
            q.push_back('{lane: lane, id: m_next_id});
            m_next_id  = (m_next_id + 1) % 256;
            m_last     = lane;
            m_has_last = 1;
        end
        m_dropped = tick && !accept;
    endtask

    task automatic compare_model();
        bit v;
        v = q.size() > 0;
        check("valid", spawn_valid, v);
        check("lane", spawn_lane, v ? q[0].lane : m_shown_lane);
        check("id", spawn_id, v ? q[0].id : m_shown_id);
        check("count", fifo_count, q.size());
        check("dropped", dropped, m_dropped);
    endtask

    // Drive one clock's worth of inputs, advance the model, compare at negedge.
    task automatic cycle(input bit en, input logic [2:0] rn, input bit rdy, input bit rst);
        enable      = en;
        randnum     = rn;
        spawn_ready = rdy;
        reset       = rst;
        model_step(en, int'(rn), rdy, rst);
        @(negedge clock);
        compare_model();
    endtask

    task automatic run(input int n, input bit en, input logic [2:0] rn, input bit rdy);
        for (int i = 0; i < n; i++) cycle(en, rn, rdy, 1'b0);
    endtask

    task automatic run_rand(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b1, 3'($urandom), rdy, 1'b0);
    endtask

    initial begin
        // Reset state
        cycle(1'b0, 3'd0, 1'b0, 1'b1);
        check("rst_valid", spawn_valid, 0);
        check("rst_count", fifo_count, 0);

        // First tick on the 4th enabled cycle, visible the cycle after
        run(3, 1'b1, 3'b001, 1'b1);
        check("pre_tick_valid", spawn_valid, 0);
        run(1, 1'b1, 3'b001, 1'b1);
        check("first_valid", spawn_valid, 1);
        check("first_lane", spawn_lane, 1);
        check("first_id", spawn_id, 0);

        // Raw 3 folds to lane 0; raw 0 then repeats and steps to lane 1
        cycle(1'b0, 3'd0, 1'b0, 1'b1);
        run(4, 1'b1, 3'b011, 1'b0);
        check("fold_lane", spawn_lane, 0);
        run(3, 1'b1, 3'b000, 1'b0);
        run(1, 1'b1, 3'b000, 1'b1);
        check("norep_lane", spawn_lane, 1);
        check("norep_id", spawn_id, 1);

        // Saturation and drop
        cycle(1'b0, 3'd0, 1'b0, 1'b1);
        run_rand(16, 1'b0);
        check("sat_count", fifo_count, 4);
        run_rand(4, 1'b0);
        check("drop_pulse", dropped, 1);
        check("drop_count", fifo_count, 4);
        for (int k = 0; k < 4; k++) begin
            check("drain_id", spawn_id, k);
            cycle(1'b0, 3'd0, 1'b1, 1'b0);
        end
        check("drop_gone", dropped, 0);
        check("drained_valid", spawn_valid, 0);

        // Full queue, tick coincident with a pop
        cycle(1'b0, 3'd0, 1'b0, 1'b1);
        run_rand(19, 1'b0);
        cycle(1'b1, 3'($urandom), 1'b1, 1'b0);
        check("swap_count", fifo_count, 4);
        check("swap_dropped", dropped, 0);
        check("swap_head", spawn_id, 1);

        // Pause at counter = 2, resume: tick on the 2nd enabled cycle
        cycle(1'b0, 3'd0, 1'b0, 1'b1);
        run(2, 1'b1, 3'd2, 1'b0);
        run(10, 1'b0, 3'd2, 1'b0);
        check("pause_valid", spawn_valid, 0);
        run(1, 1'b1, 3'd2, 1'b0);
        check("resume1_valid", spawn_valid, 0);
        run(1, 1'b1, 3'd2, 1'b0);
        check("resume2_valid", spawn_valid, 1);

        // Reset mid-queue
        cycle(1'b0, 3'd0, 1'b0, 1'b1);
        run_rand(12, 1'b0);
        check("pre_rst_count", fifo_count, 3);
        cycle(1'b1, 3'd1, 1'b0, 1'b1);
        check("mid_rst_valid", spawn_valid, 0);
        check("mid_rst_count", fifo_count, 0);
        run_rand(4, 1'b0);
        check("post_rst_id", spawn_id, 0);

        // Randomized traffic: light and heavy back-pressure phases
        for (int i = 0; i < 1200; i++) begin
            bit en, rdy, rst;
            en  = $urandom_range(0, 9) != 0;
            rdy = (i < 600) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
            rst = $urandom_range(0, 199) == 0;
            cycle(en, 3'($urandom), rdy, rst);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/obstacle_spawner.md
OBSTACLE_SPAWNER -- requirements
Module: obstacle_spawner

Interface
REQ-001 SHALL have parameter SPAWN_PERIOD, default 50, meaning enabled clock cycles between random samples (>=2).
REQ-002 SHALL have parameter NUM_LANES, default 3, meaning number of legal lanes (2..4).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning pending-spawn queue entries (power of 2).
REQ-004 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port enable  input  1  high = spawn timer runs; low = timer paused.
REQ-007 SHALL have port randnum  input  3  random value from the upstream LFSR; only bits [1:0] used.
REQ-008 SHALL have port spawn_ready  input  1  downstream consumer accepts the head entry.
REQ-009 SHALL have port spawn_valid  output  1  queue non-empty; head entry presented.
REQ-010 SHALL have port spawn_lane  output  2  lane of head entry.
REQ-011 SHALL have port spawn_id  output  8  sequence number of head entry.
REQ-012 SHALL have port fifo_count  output  3  entries currently queued (0..FIFO_DEPTH).
REQ-013 SHALL have port dropped  output  1  one-cycle pulse: a sample was discarded because the queue was full.

Function
REQ-014 SHALL implement FSM states IDLE and RUN: IDLE->RUN when enable=1; RUN->IDLE when enable=0; reset forces IDLE.
REQ-015 SHALL, in RUN, increment an interval counter each cycle from 0 to SPAWN_PERIOD-1, then wrap to 0; in IDLE the counter SHALL hold its value and not clear.
REQ-016 SHALL sample randnum on the cycle the counter equals SPAWN_PERIOD-1 in RUN (the "tick").
REQ-017 SHALL map raw = randnum[1:0] to lane = raw if raw < NUM_LANES, else raw - NUM_LANES.
REQ-018 SHALL avoid repeats: if lane equals the last accepted lane, lane becomes (lane+1) mod NUM_LANES; no repeat check before the first accepted entry after reset.
REQ-019 SHALL push {lane, next_id} at a tick when the queue is not full, or is full but a pop occurs the same cycle.
REQ-020 SHALL start next_id at 0 and increment it modulo 256 only on accepted pushes.
REQ-021 SHALL make a pushed entry visible on spawn_valid/spawn_lane/spawn_id on the cycle after the tick (1-cycle latency) when the queue was empty.
REQ-022 SHALL pop the head when spawn_valid=1 and spawn_ready=1; spawn_lane and spawn_id SHALL remain stable while spawn_valid=1 and spawn_ready=0.
REQ-023 SHALL, on a tick with queue full and no same-cycle pop, discard the sample, assert dropped for exactly the following cycle, and leave next_id and last lane unchanged.
REQ-024 SHALL update fifo_count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-025 SHALL continue draining the queue while in IDLE.
REQ-026 SHALL hold spawn_lane and spawn_id at their last value (no requirement on content) when spawn_valid=0.

Reset
REQ-027 SHALL, when reset=1 at a clock edge, set state IDLE, counter 0, next_id 0, queue empty, the repeat-check history cleared, spawn_valid 0, spawn_lane 0, spawn_id 0, fifo_count 0, dropped 0.
REQ-028 SHALL give reset priority over every simultaneous tick, push, or pop, including mid-transfer.

Structure
REQ-029 SHALL take the lane type (2-bit), NUM_LANES default, and SPAWN_PERIOD default from the shared game package.
REQ-030 SHALL instantiate a single sub-module spawn_fifo (synchronous FIFO, 10-bit entries {lane,id}, count output); FSM, timer and lane mapping SHALL reside in obstacle_spawner.

Verification (SPAWN_PERIOD=4, NUM_LANES=3, FIFO_DEPTH=4)
REQ-031 SHALL cover: reset, then enable=1, randnum=3'b001, spawn_ready=1 -> tick at 4th enabled cycle; spawn_valid=1, spawn_lane=1, spawn_id=0 on the 5th cycle.
REQ-032 SHALL cover: randnum=3'b011 on the first tick -> spawn_lane=0; randnum=3'b000 on the next tick -> repeat rule gives spawn_lane=1, spawn_id=1.
REQ-033 SHALL cover: spawn_ready=0 for 5 ticks with varying randnum -> fifo_count saturates at 4; the 5th tick gives a 1-cycle dropped pulse; spawn_ids popped afterwards are 0,1,2,3.
REQ-034 SHALL cover: queue full, with the tick coincident with spawn_ready=1 -> pop and push both happen, fifo_count stays 4, and dropped stays 0.
REQ-035 SHALL cover: enable dropped at counter=2 for 10 cycles, then restored -> tick occurs on the 2nd enabled cycle after resume.
REQ-036 SHALL cover: reset asserted with 3 entries queued and spawn_ready=0 -> next cycle spawn_valid=0, fifo_count=0, and the next accepted entry has spawn_id=0.
